// File: rtl/shift_rows_stream.sv
// Streaming Rijndael ShiftRows/InvShiftRows for NB = 4, 6 or 8 columns, followed by a DEPTH-entry output FIFO.
// Optional feature: define SHIFT_ROWS_STREAM_BYPASS_EN to add in_bypass, which stores entries untransformed.
module shift_rows_stream #(
  parameter int NB    = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [32*NB-1:0]         in_data,
  input  logic                     in_inv,
`ifdef SHIFT_ROWS_STREAM_BYPASS_EN
  input  logic                     in_bypass,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [32*NB-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int W  = 32 * NB;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Byte k sits at the MSB end; column-major with byte index 4*col + row.
  function automatic logic [W-1:0] shift_rows(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] r;
    int           off;
    int           src_col;
    r = '0;
    for (int row = 0; row < 4; row++) begin
      off = (NB == 8 && row >= 2) ? row + 1 : row;
      for (int col = 0; col < NB; col++) begin
        src_col = inv ? (col - off + NB) % NB : (col + off) % NB;
        r[W-1-8*(4*col+row) -: 8] = d[W-1-8*(4*src_col+row) -: 8];
      end
    end
    return r;
  endfunction

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  entry;
  logic          push;
  logic          pop;

`ifdef SHIFT_ROWS_STREAM_BYPASS_EN
  assign entry = in_bypass ? in_data : shift_rows(in_data, in_inv);
`else
  assign entry = shift_rows(in_data, in_inv);
`endif

  // Handshakes depend only on registered level and flush, never on out_ready feeding in_ready.
  assign in_ready  = (level_q != LW'(DEPTH)) && !flush;
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign level     = level_q;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: buffer storage is deliberately not reset; out_data is gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

endmodule
